// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder (two half_adder_df cells + carry flop) with start/ready/done handshake
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.

module half_adder_df (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    half_adder_df u_ha0 (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    half_adder_df u_ha1 (
        .a_i     (ha0_sum),
        .b_i     (c_q),
        .sum_o   (ha1_sum),
        .carry_o (ha1_carry)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1: the forced carry-in supplies the +1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                r_sh_d = {ha1_sum, r_sh_q[WIDTH-1:1]};
                c_d    = ha0_carry | ha1_carry;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = r_sh_d;
                    cout_d  = c_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready, busy, done, cout;
    logic [WIDTH-1:0] sum;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_ready"}, ready, 1'b1);
    endtask

    // One full operation: checks handshake timing, hold of the previous result, and the new result.
    task automatic do_op(input string name, input vec_t v);
        int cyc;
        int busy_bad;
        int hold_bad;
        wait_ready(name);
        a = v.a; b = v.b; cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = v.sub;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        chk({name, "_ready_low"}, ready, 1'b0);
        cyc = 1;
        busy_bad = 0;
        hold_bad = 0;
        while (!done && cyc < 20) begin
            if (!busy) busy_bad++;
            if (sum !== last_sum || cout !== last_cout) hold_bad++;
            tick();
            cyc++;
        end
        chk({name, "_latency"}, cyc, 9);
        chk({name, "_busy_run"}, busy_bad, 0);
        chk({name, "_hold"}, hold_bad, 0);
        chk({name, "_sum"}, sum, v.exp_sum);
        chk({name, "_cout"}, cout, v.exp_cout);
        chk({name, "_busy_done"}, busy, 1'b0);
        tick();
        chk({name, "_done_pulse"}, done, 1'b0);
        chk({name, "_ready_after"}, ready, 1'b1);
        last_sum  = v.exp_sum;
        last_cout = v.exp_cout;
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        int done_cnt;
        int done_at[$];
        int ready_at;
        logic [7:0] sums[$];
        int bad;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        last_sum = '0;
        last_cout = 1'b0;
        tick();
        tick();
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start re-pulsed mid-RUN with new operands must be ignored
        wait_ready("ignore");
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'hF0; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00;
        done_cnt = 0;
        ready_at = 0;
        done_at.delete();
        for (int i = 3; i <= 20; i++) begin
            if (done) begin
                done_cnt++;
                done_at.push_back(i);
                chk("ignore_sum", sum, 8'h02);
            end
            if (ready && ready_at == 0) ready_at = i;
            tick();
        end
        chk("ignore_done_cnt", done_cnt, 1);
        chk("ignore_done_cyc", (done_at.size() > 0) ? done_at[0] : -1, 9);
        chk("ignore_ready_cyc", ready_at, 10);
        last_sum = 8'h02;
        last_cout = 1'b0;

        // asynchronous reset in the 4th RUN cycle
        wait_ready("areset");
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("areset_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_ready", ready, 1'b1);
        chk("areset_busy", busy, 1'b0);
        chk("areset_sum", sum, 8'h00);
        chk("areset_done", done, 1'b0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || sum !== 8'h00) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) bad++;
        end
        chk("areset_no_done", bad, 0);
        last_sum = 8'h00;
        last_cout = 1'b0;
        v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0};
        do_op("post_reset", v);

        // start held high: one operation every WIDTH+2 cycles
        wait_ready("b2b");
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        done_at.delete();
        sums.delete();
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                done_at.push_back(i);
                sums.push_back(sum);
                chk("b2b_cout", cout, 1'b0);
            end
        end
        start = 1'b0;
        chk("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_first", done_at[0], 9);
            chk("b2b_gap1", done_at[1] - done_at[0], 10);
            chk("b2b_gap2", done_at[2] - done_at[1], 10);
            for (int i = 0; i < 3; i++) chk("b2b_sum", sums[i], 8'h10);
        end
        last_sum = 8'h10;
        last_cout = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        v = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
        do_op("sub_nb", v);
        v = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0};
        do_op("sub_borrow", v);
        v = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0};
        do_op("sub_off", v);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
